wide_add_sequencer: RTL and testbench
=====================================

// Module: wide_add_sequencer
// PURPOSE
//  Multi-precision adder controller that wraps the 8-bit carry-select adder.
//  Accepts one WIDTH-bit operand pair over a valid/ready handshake.
//  Drives the external 8-bit adder one byte slice per cycle, LSB slice first,
//  chaining the carry through a register, then presents the WIDTH-bit result.
//  Sits directly upstream (feeds a/b/cin) and downstream (takes sum/cout) of the
//  8-bit adder instance.
// PARAMETERS
//  WIDTH   32  operand/result width; must be a multiple of 8 and >= 8
//  NSLICE  WIDTH/8  (localparam) number of byte slices = RUN cycles per operation
// PORTS
//  clk        in   1      single clock; all state updates on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      operand pair valid
//  in_ready   out  1      block can accept operands (high only in IDLE)
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry into slice 0
//  add_a      out  8      byte slice of A to adder
//  add_b      out  8      byte slice of B to adder
//  add_cin    out  1      carry into adder (registered chain carry)
//  add_sum    in   8      adder sum (combinational return)
//  add_cout   in   1      adder carry out (combinational return)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result A+B+cin mod 2^WIDTH
//  out_cout   out  1      unsigned carry out of bit WIDTH-1
//  out_ovf    out  1      signed overflow: A[msb]==B[msb] && sum[msb]!=A[msb]
// BEHAVIOUR
//  Reset (async assert, sync-safe deassert): state=IDLE, idx=0, carry=0,
//   op/sum regs=0; in_ready=1 after reset, out_valid=0, out_sum=0,
//   out_cout=0, out_ovf=0. Reset mid-operation aborts; no result is produced.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//   IDLE: in_ready=1. On in_valid&in_ready: latch in_a, in_b; carry<=in_cin;
//         idx<=0; clear the sum register; go to RUN.
//   RUN : in_ready=0. add_a=A[8*idx+:8], add_b=B[8*idx+:8], add_cin=carry.
//         At each edge: sum[8*idx+:8]<=add_sum, carry<=add_cout, idx<=idx+1.
//         After the edge with idx==NSLICE-1, go to DONE.
//   DONE: out_valid=1. out_sum, out_cout=carry and out_ovf stay stable.
//         On out_ready: go to IDLE. out_valid drops the next cycle.
//  Outside RUN: add_a=0, add_b=0, add_cin=0.
//  Latency: out_valid rises exactly NSLICE cycles after the accept edge
//   (WIDTH=32 -> 4). Throughput: one op per NSLICE+2 cycles with out_ready=1.
//  in_valid outside IDLE is ignored; the upstream must hold its data until
//   in_ready is seen.
//  out_ready low holds DONE indefinitely with all outputs stable.
//  out_ready outside DONE has no effect.
//  WIDTH=8: NSLICE=1; RUN lasts exactly one cycle.
//  idx width = max(1,$clog2(NSLICE)); no wrap past NSLICE-1.
//  out_sum/out_cout/out_ovf are registered and hold their last result until
//   the next accept.
// TESTING (WIDTH=32)
//  1 A=0xFFFFFFFF,B=0x00000001,cin=0 -> out_sum=0x00000000,cout=1,ovf=0;
//    add_cin seq 0,1,1,1 over RUN
//  2 A=0x7FFFFFFF,B=0x00000001,cin=0 -> out_sum=0x80000000,cout=0,ovf=1;
//    A=0x80000000,B=0x80000000 -> sum=0,cout=1,ovf=1
//  3 A=0x12345678,B=0x11111111,cin=1 -> add_a seq 78,56,34,12;
//    add_b 11x4; out_sum=0x2345678A; out_valid 4 cycles after accept
//  4 out_ready held low 6 cycles in DONE -> out_valid/out_sum stable,
//    in_ready=0, in_valid pulses ignored; after out_ready=1, next op accepted
//  5 rst_n low during 2nd RUN cycle -> out_valid=0, in_ready=1, add_*=0
//    immediately; the next op gives the correct result
//  6 1000 random A/B/cin with random out_ready stalls -> out_sum/cout/ovf
//    match the reference model

Source files
------------

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - byte-serial multi-precision adder controller around an external 8-bit adder
//
// Purpose:
//   Accepts one WIDTH-bit operand pair on a valid/ready handshake.
//   Feeds the external 8-bit adder one byte slice per cycle, LSB slice first.
//   The carry is chained through a register between slices.
//   Then holds the WIDTH-bit sum, carry out and signed overflow until the result is taken.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready          operand handshake (in_ready high only in IDLE)
//   in_a, in_b, in_cin         operands and carry into slice 0
//   add_a, add_b, add_cin      byte slice and chain carry driven to the adder
//   add_sum, add_cout          combinational return from the adder
//   out_valid/out_ready        result handshake
//   out_sum, out_cout, out_ovf result, unsigned carry out, signed overflow
module wide_add_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_cin,
  output logic [7:0]       add_a,
  output logic [7:0]       add_b,
  output logic             add_cin,
  input  logic [7:0]       add_sum,
  input  logic             add_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf
);

  localparam int NSLICE = WIDTH / 8;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(NSLICE - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t           r_state;
  logic [IW-1:0]    r_idx;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_ovf;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [7:0]       r_add_a;
  logic [7:0]       r_add_b;
  logic             r_add_cin;
  logic             w_last;

  assign w_last = (r_idx == LAST_IDX);

  // The adder-facing slice registers are loaded one cycle ahead.
  // Each RUN cycle therefore presents the slice for the current r_idx straight from flops.
  // They are zeroed on the last RUN edge, so the adder sees 0 outside RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_add_cin   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a        <= in_a;
            r_b        <= in_b;
            r_carry    <= in_cin;
            r_idx      <= '0;
            r_sum      <= '0;
            r_ovf      <= 1'b0;
            r_add_a    <= in_a[7:0];
            r_add_b    <= in_b[7:0];
            r_add_cin  <= in_cin;
            r_in_ready <= 1'b0;
            r_state    <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum[8*r_idx +: 8] <= add_sum;
          r_carry             <= add_cout;
          if (w_last) begin
            // Signed overflow: like-signed operands produced an opposite-signed sum.
            r_ovf       <= (r_a[WIDTH-1] == r_b[WIDTH-1]) && (add_sum[7] != r_a[WIDTH-1]);
            r_add_a     <= '0;
            r_add_b     <= '0;
            r_add_cin   <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= S_DONE;
          end else begin
            r_idx     <= r_idx + 1'b1;
            r_add_a   <= r_a[8*(r_idx+1) +: 8];
            r_add_b   <= r_b[8*(r_idx+1) +: 8];
            r_add_cin <= add_cout;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign add_a     = r_add_a;
  assign add_b     = r_add_b;
  assign add_cin   = r_add_cin;
  assign out_sum   = r_sum;
  assign out_cout  = r_carry;
  assign out_ovf   = r_ovf;

endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer (WIDTH=32)
module tb_wide_add_sequencer;

  localparam int WIDTH  = 32;
  localparam int NSLICE = WIDTH / 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = '0;
  logic [WIDTH-1:0] in_b = '0;
  logic             in_cin = 1'b0;
  logic [7:0]       add_a;
  logic [7:0]       add_b;
  logic             add_cin;
  logic [7:0]       add_sum;
  logic             add_cout;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;

  wide_add_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
    .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  // External 8-bit adder.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_cin};

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: outstanding operations with the cycle of their accept edge.
  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    int          acc;
  } op_t;
  op_t q[$];

  function automatic logic [32:0] ref_sum(input op_t o);
    return {1'b0, o.a} + {1'b0, o.b} + {32'd0, o.cin};
  endfunction

  function automatic logic ref_ovf(input op_t o);
    logic [32:0] s;
    s = ref_sum(o);
    return (o.a[31] == o.b[31]) && (s[31] != o.a[31]);
  endfunction

  // Carry entering slice k = bit 8k of the sum of the low 8k bits plus cin.
  function automatic logic ref_carry_in(input op_t o, input int k);
    logic [63:0] m;
    logic [63:0] lo;
    m  = (64'd1 << (8 * k)) - 64'd1;
    lo = ({32'd0, o.a} & m) + ({32'd0, o.b} & m) + {63'd0, o.cin};
    return lo[8*k];
  endfunction

  int   k;
  logic prev_valid = 1'b0;
  logic [32:0] s_exp;

  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      prev_valid = 1'b0;
    end else begin
      chk("in_ready", 64'(in_ready), 64'(q.size() == 0));
      if (q.size() != 0 && !out_valid) begin
        k = cyc - q[0].acc;
        if (k >= 0 && k < NSLICE) begin
          chk("run_add_a", 64'(add_a), 64'((q[0].a >> (8 * k)) & 32'hFF));
          chk("run_add_b", 64'(add_b), 64'((q[0].b >> (8 * k)) & 32'hFF));
          chk("run_add_cin", 64'(add_cin), 64'(ref_carry_in(q[0], k)));
        end else begin
          chk("run_length", 64'(k), 64'(NSLICE - 1));
        end
      end else begin
        chk("idle_add_a", 64'(add_a), 64'd0);
        chk("idle_add_b", 64'(add_b), 64'd0);
        chk("idle_add_cin", 64'(add_cin), 64'd0);
      end
      if (out_valid) begin
        if (q.size() == 0) begin
          chk("unexpected_out_valid", 64'd1, 64'd0);
        end else begin
          if (!prev_valid) chk("latency", 64'(cyc - q[0].acc), 64'(NSLICE));
          s_exp = ref_sum(q[0]);
          chk("out_sum", 64'(out_sum), 64'(s_exp[31:0]));
          chk("out_cout", 64'(out_cout), 64'(s_exp[32]));
          chk("out_ovf", 64'(out_ovf), 64'(ref_ovf(q[0])));
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_valid = out_valid;
      if (in_valid && in_ready) q.push_back('{a: in_a, b: in_b, cin: in_cin, acc: cyc + 1});
    end
  end

  // Called at posedge+1; returns at posedge+1 right after the accept edge.
  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic cin);
    logic acc;
    int   n;
    in_a = a; in_b = b; in_cin = cin; in_valid = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!acc && n < 100);
    if (!acc) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_cin = ~cin;
  endtask

  task automatic recv(input int stall, output logic [31:0] s, output logic c, output logic o);
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) chk("result_timeout", 64'd0, 64'd1);
    repeat (stall) @(negedge clk);
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    s = out_sum; c = out_cout; o = out_ovf;
    @(posedge clk);
    #1 out_ready = 1'b0;
  endtask

  logic [7:0]  seq_a [NSLICE];
  logic [7:0]  seq_b [NSLICE];
  logic        seq_c [NSLICE];
  task automatic capture_run();
    for (int i = 0; i < NSLICE; i++) begin
      @(negedge clk);
      seq_a[i] = add_a; seq_b[i] = add_b; seq_c[i] = add_cin;
    end
  endtask

  logic [31:0] rs;
  logic        rc;
  logic        ro;
  logic [31:0] hold;

  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_sum", 64'(out_sum), 64'd0);
    chk("rst_out_cout", 64'(out_cout), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    chk("rst_add_a", 64'(add_a), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // 1: all-ones plus one, carry ripples through every slice
    send(32'hFFFFFFFF, 32'h00000001, 1'b0);
    capture_run();
    chk("t1_cin_seq", 64'({seq_c[0], seq_c[1], seq_c[2], seq_c[3]}), 64'b0111);
    recv(0, rs, rc, ro);
    chk("t1_sum", 64'(rs), 64'h0);
    chk("t1_cout", 64'(rc), 64'd1);
    chk("t1_ovf", 64'(ro), 64'd0);

    // 2: signed overflow both directions
    send(32'h7FFFFFFF, 32'h00000001, 1'b0);
    recv(1, rs, rc, ro);
    chk("t2a_sum", 64'(rs), 64'h80000000);
    chk("t2a_cout", 64'(rc), 64'd0);
    chk("t2a_ovf", 64'(ro), 64'd1);
    send(32'h80000000, 32'h80000000, 1'b0);
    recv(0, rs, rc, ro);
    chk("t2b_sum", 64'(rs), 64'h0);
    chk("t2b_cout", 64'(rc), 64'd1);
    chk("t2b_ovf", 64'(ro), 64'd1);

    // 3: slice order and carry-in
    send(32'h12345678, 32'h11111111, 1'b1);
    capture_run();
    chk("t3_add_a_seq", 64'({seq_a[0], seq_a[1], seq_a[2], seq_a[3]}), 64'h78563412);
    chk("t3_add_b_seq", 64'({seq_b[0], seq_b[1], seq_b[2], seq_b[3]}), 64'h11111111);
    recv(0, rs, rc, ro);
    chk("t3_sum", 64'(rs), 64'h2345678A);
    chk("t3_ovf", 64'(ro), 64'd0);

    // 4: DONE held with out_ready low; in_valid pulses ignored
    send(32'hA5A5A5A5, 32'h5A5A5A5B, 1'b0);
    @(negedge clk);
    while (!out_valid && cyc < 100000) @(negedge clk);
    hold = out_sum;
    chk("t4_hold_value", 64'(hold), 64'h0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1 in_valid = (i % 2 == 0); in_a = $urandom; in_b = $urandom;
      @(negedge clk);
      chk("t4_in_ready", 64'(in_ready), 64'd0);
      chk("t4_out_valid", 64'(out_valid), 64'd1);
      chk("t4_out_sum_stable", 64'(out_sum), 64'(hold));
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
    recv(0, rs, rc, ro);
    chk("t4_cout", 64'(rc), 64'd1);
    send(32'h00000010, 32'h00000020, 1'b0);
    recv(0, rs, rc, ro);
    chk("t4_next_sum", 64'(rs), 64'h30);

    // 5: reset during the second RUN cycle aborts the op
    send(32'hDEADBEEF, 32'h01010101, 1'b1);
    @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("t5_in_ready", 64'(in_ready), 64'd1);
    chk("t5_out_valid", 64'(out_valid), 64'd0);
    chk("t5_add_a", 64'(add_a), 64'd0);
    chk("t5_add_b", 64'(add_b), 64'd0);
    chk("t5_add_cin", 64'(add_cin), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    send(32'h0000FFFF, 32'h00000001, 1'b0);
    recv(0, rs, rc, ro);
    chk("t5_next_sum", 64'(rs), 64'h00010000);
    chk("t5_next_cout", 64'(rc), 64'd0);

    // 6: random operands with random result stalls, checked by the model
    for (int i = 0; i < 1000; i++) begin
      send($urandom, $urandom, 1'($urandom_range(0, 1)));
      recv($urandom_range(0, 3), rs, rc, ro);
    end

    repeat (3) @(posedge clk);
    chk("final_queue_empty", 64'(q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
